uart_transmitter: RTL and testbench

// Serial transmit half of the UART: accepts a byte from the processor bus,

---
 rtl/uart_transmitter.sv | 139 +++++++++++++
 tb/tb_uart_transmitter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : Serial transmit half of the UART. Accepts a byte from the
//               processor bus into a one-entry holding buffer, frames it as
//               start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop
//               bits, and drives it onto txd. Bit timing is paced by the
//               shared 16x baud enable (t_enable).
// Ports       :
//   clk        in   1          system clock, all logic on posedge
//   rst        in   1          synchronous reset, active-low (0 = reset)
//   t_enable   in   1          oversample enable from baud generator
//   tx_enable  in   1          one-clk write strobe for data_in
//   data_in    in   DATA_BITS  byte from processor bus
//   txd        out  1          serial output, registered, idle high
//   tbr        out  1          transmit buffer ready (holding buffer empty)
//   tx_busy    out  1          shift engine active (START/DATA/STOP)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t_enable,
  input  logic                 tx_enable,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy
);

  localparam int SMP_W = $clog2(OVERSAMPLE);
  // Wide enough for DATA_BITS-1 and STOP_BITS-1 (STOP_BITS <= 2).
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic [SMP_W-1:0]     smp;
  logic [BIT_W-1:0]     bitn;
  logic                 bit_end;

  // A bit period closes on the OVERSAMPLE-th enable pulse counted within it.
  assign bit_end = t_enable && (smp == SMP_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      hold    <= '0;
      shift   <= '0;
      smp     <= '0;
      bitn    <= '0;
      txd     <= 1'b1;
      tbr     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      // Processor write only lands in an empty buffer; the IDLE transfer
      // below needs tbr==0, so both never update hold/tbr in the same edge.
      if (tx_enable && tbr) begin
        hold <= data_in;
        tbr  <= 1'b0;
      end

      // Oversample counter runs only while a frame is on the line.
      if (state != IDLE && t_enable) begin
        smp <= bit_end ? '0 : smp + SMP_W'(1);
      end

      unique case (state)
        IDLE: begin
          txd     <= 1'b1;
          tx_busy <= 1'b0;
          if (!tbr) begin
            shift   <= hold;
            tbr     <= 1'b1;
            txd     <= 1'b0;
            tx_busy <= 1'b1;
            smp     <= '0;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            // Present bit 0 and pre-shift so DATA always drives shift[0].
            txd   <= shift[0];
            shift <= shift >> 1;
            bitn  <= '0;
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bitn == DATA_LAST) begin
              txd   <= 1'b1;
              bitn  <= '0;
              state <= STOP;
            end else begin
              txd   <= shift[0];
              shift <= shift >> 1;
              bitn  <= bitn + BIT_W'(1);
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (bitn == STOP_LAST) begin
              bitn    <= '0;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              bitn <= bitn + BIT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter. Written bytes are
//               pushed to an expected queue; a line monitor decodes frames
//               from txd (bit boundaries found by counting t_enable pulses)
//               and pops/compares each decoded byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;
  localparam int NBITS      = 1 + DATA_BITS + STOP_BITS;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       t_enable  = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] data_in   = 8'h00;
  logic       txd;
  logic       tbr;
  logic       tx_busy;

  uart_transmitter #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_enable (t_enable),
    .tx_enable(tx_enable),
    .data_in  (data_in),
    .txd      (txd),
    .tbr      (tbr),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic       te_at_edge  = 1'b0;
  int         te_div      = 1;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         len_min     = 0;
  int         len_max     = 0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    te_at_edge <= t_enable;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Baud enable: one pulse every te_div clocks, driven off the falling edge.
  initial begin : ten_gen
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k >= te_div) k = 0;
      t_enable = (k == 0);
    end
  end

  // Line monitor: decode frames from txd, compare against the expected queue.
  initial begin : line_monitor
    logic       prev;
    logic       cur;
    logic       stop_ok;
    logic       aborted;
    logic [7:0] got;
    logic [7:0] exp_b;
    int         b;
    int         cnt;
    int         bit_start;
    int         glitches;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else if (prev && !txd) begin
        start_cyc.push_back(cyc);
        b = 0; cnt = 0; bit_start = cyc; cur = 1'b0; got = '0;
        stop_ok = 1'b1; glitches = 0; aborted = 1'b0;
        len_min = 1 << 30; len_max = 0;
        while (b < NBITS && !aborted) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
          end else begin
            if (te_at_edge) cnt++;
            if (cnt == OVERSAMPLE) begin
              if (b > 0) begin
                if (cyc - bit_start < len_min) len_min = cyc - bit_start;
                if (cyc - bit_start > len_max) len_max = cyc - bit_start;
              end
              cnt = 0; b++; bit_start = cyc; cur = txd;
              if (b >= 1 && b <= DATA_BITS) got[b-1] = txd;
              else if (b > DATA_BITS && b < NBITS) stop_ok = stop_ok & txd;
            end else if (txd !== cur) begin
              glitches++;
            end
          end
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            check("frame_expected_pending", 32'd0, 32'd1);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", {24'd0, got}, {24'd0, exp_b});
          end
          check("frame_stop", {31'd0, stop_ok}, 32'd1);
          check("frame_glitch", glitches, 32'd0);
          check("busy_after_frame", {31'd0, tx_busy}, 32'd0);
          prev = txd;
        end
      end else begin
        prev = txd;
      end
    end
  end

  // Drive one write strobe for the next posedge; caller sits on a negedge.
  task automatic write_byte(input logic [7:0] b, input bit accept);
    data_in   = b;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    data_in   = ~b;
    if (accept) begin
      exp_q.push_back(b);
      check("tbr_low_after_write", {31'd0, tbr}, 32'd0);
    end
  endtask

  task automatic wait_idle(input int limit);
    int waited;
    waited = 0;
    while (!(tx_busy === 1'b0 && tbr === 1'b1) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("idle_reached", {30'd0, tx_busy, tbr}, 32'd1);
  endtask

  task automatic wait_tbr(input int limit);
    int waited;
    waited = 0;
    while (tbr !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("tbr_rise_reached", {31'd0, tbr}, 32'd1);
  endtask

  initial begin : stimulus
    int w;

    // 1: reset held with a write strobe active.
    rst = 1'b0; tx_enable = 1'b1; data_in = 8'h77;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_tbr", {31'd0, tbr}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    tx_enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_txd", {31'd0, txd}, 32'd1);
    check("post_reset_tbr", {31'd0, tbr}, 32'd1);

    // 2: single byte 0xA5, enable every clock.
    te_div = 1;
    write_byte(8'hA5, 1'b1);
    w = cyc;
    @(negedge clk);
    check("start_latency_txd", {31'd0, txd}, 32'd0);
    check("tbr_back_high", {31'd0, tbr}, 32'd1);
    check("busy_in_frame", {31'd0, tx_busy}, 32'd1);
    wait_idle(400);
    check("busy_duration", cyc - w, 32'(1 + NBITS * OVERSAMPLE));
    repeat (3) @(negedge clk);

    // 3: back-to-back 0x00 then 0xFF as soon as tbr rises.
    start_cyc.delete();
    write_byte(8'h00, 1'b1);
    wait_tbr(10);
    write_byte(8'hFF, 1'b1);
    wait_idle(800);
    repeat (3) @(negedge clk);
    check("b2b_frames", start_cyc.size(), 32'd2);
    if (start_cyc.size() >= 2)
      check("b2b_gap", start_cyc[1] - start_cyc[0], 32'(NBITS * OVERSAMPLE + 1));

    // 4: writes while the buffer is full are dropped.
    write_byte(8'h3C, 1'b1);
    write_byte(8'hC3, 1'b0);
    check("tbr_after_ignored", {31'd0, tbr}, 32'd1);
    repeat (20) @(negedge clk);
    write_byte(8'h11, 1'b1);
    repeat (5) @(negedge clk);
    write_byte(8'h22, 1'b0);
    check("tbr_held_low", {31'd0, tbr}, 32'd0);
    wait_idle(800);
    repeat (3) @(negedge clk);
    check("drop_queue_empty", exp_q.size(), 32'd0);

    // 5: enable every 4 clocks -> 64-clock bit periods.
    te_div = 4;
    repeat (4) @(negedge clk);
    write_byte(8'h96, 1'b1);
    wait_idle(1500);
    repeat (3) @(negedge clk);
    check("slow_bit_min", len_min, 32'(4 * OVERSAMPLE));
    check("slow_bit_max", len_max, 32'(4 * OVERSAMPLE));

    // 6: reset mid-DATA of 0x55, then a clean 0x81.
    te_div = 1;
    repeat (2) @(negedge clk);
    write_byte(8'h55, 1'b1);
    repeat (40) @(negedge clk);
    check("mid_frame_busy", {31'd0, tx_busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_txd", {31'd0, txd}, 32'd1);
    check("midreset_tbr", {31'd0, tbr}, 32'd1);
    check("midreset_busy", {31'd0, tx_busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {31'd0, txd}, 32'd1);
    write_byte(8'h81, 1'b1);
    wait_idle(400);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
